// File: rtl/pattern_scan_pkg.sv
// Shared types and helpers for the pattern-count accelerator.
package pattern_scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_PAT, S_SCAN, S_DRAIN, S_WB0, S_WB1, S_WB2, S_DONE
  } state_t;

  // Counter width able to hold every stream position count for n bytes.
  function automatic int cnt_width(input int n_bytes);
    return $clog2(8 * n_bytes + 1);
  endfunction

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

endpackage

// File: rtl/window_match.sv
// Combinational window compare for one message byte plus the carried tail bits.
module window_match import pattern_scan_pkg::*; #(
  parameter int PAT_W = 5
) (
  input  logic [PAT_W-1:0] pat,
  input  logic [7:0]       byte_in,
  input  logic [PAT_W-2:0] tail,
  input  logic             cross_en,
  output logic [3:0]       n_in,
  output logic [3:0]       n_cross,
  output logic             any_in,
  output logic             hit,
  output logic [2:0]       first_off
);
  localparam int CW = PAT_W + 7;

  logic [CW-1:0] cat;
  logic [7:0]    m;

  assign cat = {tail, byte_in};

  // Window t starts t bits after the oldest tail bit; t < PAT_W-1 straddles two bytes.
  for (genvar t = 0; t < 8; t++) begin : g_win
    assign m[t] = (cat[CW-1-t -: PAT_W] == pat) && ((t >= PAT_W - 1) || cross_en);
  end

  always_comb begin
    n_in      = '0;
    n_cross   = '0;
    first_off = '0;
    for (int t = 7; t >= 0; t--) begin
      if (m[t]) first_off = 3'(t);
      if (t >= PAT_W - 1) n_in = n_in + 4'(m[t]);
      else                n_cross = n_cross + 4'(m[t]);
    end
  end

  assign hit    = |m;
  assign any_in = |m[7:PAT_W-1];

endmodule

// File: rtl/pattern_scan_engine.sv
// Pattern-count accelerator: fetches pattern and message over one memory port,
// counts in-byte / per-byte / stream matches and writes the counts back.
module pattern_scan_engine import pattern_scan_pkg::*; #(
  parameter  int PAT_W    = 5,
  parameter  int N_BYTES  = 32,
  parameter  int MSG_ADDR = 0,
  parameter  int PAT_ADDR = 32,
  parameter  int RES_ADDR = 33,
  localparam int CNT_W    = cnt_width(N_BYTES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [7:0]       mem_addr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  output logic [CNT_W-1:0] cnt_inbyte,
  output logic [CNT_W-1:0] cnt_bytes,
  output logic [CNT_W-1:0] cnt_stream,
  output logic [CNT_W-1:0] first_pos,
  output logic             first_vld,
  output logic             busy,
  output logic             done
);
  localparam int IW = $clog2(N_BYTES + 1);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] tail_q, tail_d;
  logic [IW-1:0]    iss_q, iss_d, pidx_q, pidx_d;
  logic [7:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic             we_q, we_d, busy_q, busy_d, done_q, done_d, fvld_q, fvld_d;
  logic [CNT_W-1:0] cin_q, cin_d, cby_q, cby_d, cst_q, cst_d, fpos_q, fpos_d;

  logic [3:0]       n_in, n_cross;
  logic             any_in, hit, proc;
  logic [2:0]       first_off;
  logic [CNT_W-1:0] pos;

  window_match #(.PAT_W(PAT_W)) u_win (
    .pat       (pat_q),
    .byte_in   (mem_rdata),
    .tail      (tail_q),
    .cross_en  (pidx_q != '0),
    .n_in      (n_in),
    .n_cross   (n_cross),
    .any_in    (any_in),
    .hit       (hit),
    .first_off (first_off)
  );

  assign proc = (state_q == S_SCAN) || (state_q == S_DRAIN);
  // Window offset is measured from the oldest tail bit, i.e. PAT_W-1 bits before this byte.
  assign pos  = CNT_W'({pidx_q, 3'b000}) + CNT_W'(first_off) - CNT_W'(PAT_W - 1);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    tail_d  = tail_q;
    iss_d   = iss_q;
    pidx_d  = pidx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    fvld_d  = fvld_q;
    fpos_d  = fpos_q;
    cin_d   = cin_q;
    cby_d   = cby_q;
    cst_d   = cst_q;

    if (proc) begin
      cin_d  = cin_q + CNT_W'(n_in);
      cby_d  = cby_q + CNT_W'(any_in);
      cst_d  = cst_q + CNT_W'(n_in) + CNT_W'(n_cross);
      tail_d = mem_rdata[PAT_W-2:0];
      pidx_d = pidx_q + IW'(1);
      if (hit && !fvld_q) begin
        fvld_d = 1'b1;
        fpos_d = pos;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_FETCH_PAT;
        addr_d  = 8'(PAT_ADDR);
        busy_d  = 1'b1;
        done_d  = 1'b0;
        fvld_d  = 1'b0;
        fpos_d  = '0;
        cin_d   = '0;
        cby_d   = '0;
        cst_d   = '0;
      end
      S_FETCH_PAT: begin
        pat_d   = mem_rdata[7 -: PAT_W];
        addr_d  = 8'(MSG_ADDR);
        iss_d   = IW'(1);
        pidx_d  = '0;
        state_d = (N_BYTES == 1) ? S_DRAIN : S_SCAN;
      end
      S_SCAN: begin
        addr_d = 8'(MSG_ADDR) + 8'(iss_q);
        iss_d  = iss_q + IW'(1);
        if (iss_q == IW'(N_BYTES - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_WB0;
        we_d    = 1'b1;
        addr_d  = 8'(RES_ADDR);
        wdata_d = sat8(int'(cin_d));
      end
      S_WB0: begin
        state_d = S_WB1;
        we_d    = 1'b1;
        addr_d  = 8'(RES_ADDR + 1);
        wdata_d = sat8(int'(cby_q));
      end
      S_WB1: begin
        state_d = S_WB2;
        we_d    = 1'b1;
        addr_d  = 8'(RES_ADDR + 2);
        wdata_d = sat8(int'(cst_q));
      end
      S_WB2: begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      tail_q  <= '0;
      iss_q   <= '0;
      pidx_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fvld_q  <= 1'b0;
      fpos_q  <= '0;
      cin_q   <= '0;
      cby_q   <= '0;
      cst_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      tail_q  <= tail_d;
      iss_q   <= iss_d;
      pidx_q  <= pidx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fvld_q  <= fvld_d;
      fpos_q  <= fpos_d;
      cin_q   <= cin_d;
      cby_q   <= cby_d;
      cst_q   <= cst_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_wdata  = wdata_q;
  assign cnt_inbyte = cin_q;
  assign cnt_bytes  = cby_q;
  assign cnt_stream = cst_q;
  assign first_pos  = fpos_q;
  assign first_vld  = fvld_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
